decode_s1_skid: RTL and testbench

Two-entry skid buffer between decode stage 1 and decode stage 2. It registers the stage 1 output bundle (the decoded control payload plus PC) and presents it to stage 2 under a valid/ready handshake. Its upstream ready is a pure register output, which breaks the combinational ready path from stage 2 back into stage 1's ROM/repeat/interrupt masking logic. A flush discards everything held in the buffer.

---
 rtl/decode_s1_skid.sv | 93 +++++++++
 tb/tb_decode_s1_skid.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_s1_skid.sv
// rtl/decode_s1_skid.sv - two-entry skid buffer between decode stage 1 and decode stage 2
module decode_s1_skid #(
    parameter int PW     = 160,
    parameter int IADDRW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [PW-1:0]     s1_payload,
    input  logic [IADDRW-1:0] s1_pc,
    output logic              s2_valid,
    input  logic              s2_ready,
    output logic [PW-1:0]     s2_payload,
    output logic [IADDRW-1:0] s2_pc,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [PW-1:0]     payload_q [2];
    logic [IADDRW-1:0] pc_q      [2];
    logic              push;
    logic              pop;

    assign push = s1_valid & s1_ready & ~flush;
    assign pop  = s2_valid & s2_ready & ~flush;

    // No bypass: an empty buffer only ever moves to ONE, never forwards same-cycle.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) state_next = ONE;
                ONE: begin
                    if (push && !pop)      state_next = FULL;
                    else if (pop && !push) state_next = EMPTY;
                end
                FULL:  if (pop) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Ready and valid are registered from the next state so neither depends
    // combinationally on s2_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            s1_ready <= 1'b1;
            s2_valid <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                payload_q[i] <= '0;
                pc_q[i]      <= '0;
            end
        end else begin
            state    <= state_next;
            s1_ready <= (state_next != FULL);
            s2_valid <= (state_next != EMPTY);
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    payload_q[wr_ptr] <= s1_payload;
                    pc_q[wr_ptr]      <= s1_pc;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

    assign s2_payload = payload_q[rd_ptr];
    assign s2_pc      = pc_q[rd_ptr];
    assign occupancy  = state;

endmodule

// File: tb/tb_decode_s1_skid.sv
// tb/tb_decode_s1_skid.sv - self-checking bench for decode_s1_skid
module tb_decode_s1_skid;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         s1_valid = 1'b0;
    logic         s1_ready;
    logic [159:0] s1_payload = '0;
    logic [31:0]  s1_pc = '0;
    logic         s2_valid;
    logic         s2_ready = 1'b0;
    logic [159:0] s2_payload;
    logic [31:0]  s2_pc;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [31:0]  exp_pc_q [$];
    logic [159:0] exp_pl_q [$];
    bit acc;

    decode_s1_skid #(.PW(160), .IADDRW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_payload (s1_payload),
        .s1_pc      (s1_pc),
        .s2_valid   (s2_valid),
        .s2_ready   (s2_ready),
        .s2_payload (s2_payload),
        .s2_pc      (s2_pc),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] rnd160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called 1 time unit after an edge with inputs already driven; checks outputs,
    // scores the handshakes for the coming edge, then advances to just past it.
    task automatic cycle(output bit accepted);
        bit popped;
        chk("s1_ready", s1_ready, exp_cnt < 2);
        chk("s2_valid", s2_valid, exp_cnt != 0);
        chk("occupancy", occupancy, exp_cnt[1:0]);
        if (exp_cnt != 0) begin
            chk("s2_pc", s2_pc, exp_pc_q[0]);
            chk("s2_payload", s2_payload, exp_pl_q[0]);
        end
        accepted = s1_valid && (exp_cnt < 2) && !flush;
        popped   = s2_ready && (exp_cnt != 0) && !flush;
        if (flush) begin
            exp_pc_q.delete();
            exp_pl_q.delete();
            exp_cnt = 0;
        end else begin
            if (popped) begin
                void'(exp_pc_q.pop_front());
                void'(exp_pl_q.pop_front());
                exp_cnt--;
            end
            if (accepted) begin
                exp_pc_q.push_back(s1_pc);
                exp_pl_q.push_back(s1_payload);
                exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [159:0] pl);
        bit a;
        int n;
        s1_valid   = 1'b1;
        s1_pc      = pc;
        s1_payload = pl;
        a = 1'b0;
        n = 0;
        while (!a && n < 20) begin
            cycle(a);
            n++;
        end
        if (!a) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        bit a;
        s1_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(a);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_s2_valid", s2_valid, 1'b0);
        chk("rst_s1_ready", s1_ready, 1'b1);
        chk("rst_occupancy", occupancy, 2'd0);
        chk("rst_s2_pc", s2_pc, 32'h0);
        chk("rst_s2_payload", s2_payload, 160'h0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // single push, one-cycle latency, then drain
        s2_ready = 1'b1;
        send(32'h1000, 160'hA5);
        idle(2);

        // streaming at full rate
        for (int i = 0; i < 8; i++) send(32'h100 + i, rnd160());
        idle(2);

        // back-pressure: third bundle must be held upstream
        s2_ready = 1'b0;
        send(32'h200, rnd160());
        send(32'h201, rnd160());
        s1_pc = 32'h202;
        s1_payload = rnd160();
        cycle(acc);
        chk("held_0x202", acc, 1'b0);
        cycle(acc);
        chk("held_0x202_again", acc, 1'b0);
        s2_ready = 1'b1;
        send(32'h202, s1_payload);
        idle(3);

        // wrap-around: fill to two, drain, repeatedly
        for (int i = 0; i < 5; i++) begin
            s2_ready = 1'b0;
            send(32'h300 + 2 * i, rnd160());
            send(32'h301 + 2 * i, rnd160());
            s2_ready = 1'b1;
            idle(2);
        end
        idle(1);

        // flush beats simultaneous push and pop
        s2_ready = 1'b0;
        send(32'h3F0, rnd160());
        send(32'h3F1, rnd160());
        s1_valid = 1'b1;
        s1_pc = 32'h400;
        s1_payload = rnd160();
        s2_ready = 1'b1;
        flush = 1'b1;
        cycle(acc);
        chk("flush_drop", acc, 1'b0);
        flush = 1'b0;
        s1_valid = 1'b0;
        chk("post_flush_s2_valid", s2_valid, 1'b0);
        chk("post_flush_occupancy", occupancy, 2'd0);
        chk("post_flush_s1_ready", s1_ready, 1'b1);
        send(32'h401, rnd160());
        idle(2);

        // asynchronous reset between edges
        s2_ready = 1'b0;
        send(32'h500, rnd160());
        send(32'h501, rnd160());
        s1_valid = 1'b0;
        chk("pre_reset_occupancy", occupancy, 2'd2);
        #3 reset = 1'b1;
        #1;
        chk("async_s2_valid", s2_valid, 1'b0);
        chk("async_s1_ready", s1_ready, 1'b1);
        chk("async_occupancy", occupancy, 2'd0);
        chk("async_s2_pc", s2_pc, 32'h0);
        #2 reset = 1'b0;
        exp_pc_q.delete();
        exp_pl_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        s2_ready = 1'b1;
        send(32'h600, rnd160());
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
